prog_loader: RTL and testbench

PROG_LOADER -- requirements
Module: prog_loader

---
 rtl/prog_loader.sv | 163 ++++++++++++++++
 tb/tb_prog_loader.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/prog_loader.sv
// Program loader: assembles host bytes into 16-bit instruction words and writes them to instruction memory.
// Optional opcode check is enabled by defining PROG_LOADER_OPCHECK_EN.
module prog_loader (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Start,
    input  logic [7:0]  Len,
    input  logic        In_valid,
    input  logic [7:0]  In_data,
    output logic        In_ready,
    output logic [6:0]  I_addr,
    output logic [15:0] I_data,
    output logic        I_wr,
    output logic        Cpu_reset,
    output logic        Busy,
    output logic        Done,
    output logic        Err
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_HI     = 3'd1,
        ST_LO     = 3'd2,
        ST_WRITE  = 3'd3,
        ST_FINISH = 3'd4
    } state_t;

    state_t      state_r;
    state_t      next_state_s;
    logic [7:0]  len_r;
    logic        xfer_s;
    logic        last_word_s;
    logic        len_ok_s;

    function automatic logic len_legal(input logic [7:0] len);
        return (len != 8'd0) && (len <= 8'd128);
    endfunction

    function automatic logic opcode_illegal(input logic [3:0] op);
        return (op > 4'd5);
    endfunction

    // Next-state logic and transfer qualification
    always_comb begin
        next_state_s = state_r;
        xfer_s       = In_valid && In_ready;
        len_ok_s     = len_legal(Len);
        last_word_s  = ({1'b0, I_addr} == (len_r - 8'd1));
        case (state_r)
            ST_IDLE: begin
                if (Start && len_ok_s) begin
                    next_state_s = ST_HI;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_HI: begin
                if (xfer_s) begin
                    next_state_s = ST_LO;
                end else begin
                    next_state_s = ST_HI;
                end
            end
            ST_LO: begin
                if (xfer_s) begin
                    next_state_s = ST_WRITE;
                end else begin
                    next_state_s = ST_LO;
                end
            end
            ST_WRITE: begin
                if (last_word_s) begin
                    next_state_s = ST_FINISH;
                end else begin
                    next_state_s = ST_HI;
                end
            end
            ST_FINISH: next_state_s = ST_IDLE;
            default:   next_state_s = ST_IDLE;
        endcase
    end

    // State register; control outputs are registered from the next state so they match the state they describe
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_r   <= ST_IDLE;
            In_ready  <= 1'b0;
            I_wr      <= 1'b0;
            Busy      <= 1'b0;
            Done      <= 1'b0;
            Cpu_reset <= 1'b1;
        end else begin
            state_r   <= next_state_s;
            In_ready  <= (next_state_s == ST_HI) || (next_state_s == ST_LO);
            I_wr      <= (next_state_s == ST_WRITE);
            Busy      <= (next_state_s != ST_IDLE);
            Done      <= (next_state_s == ST_FINISH);
            Cpu_reset <= (next_state_s != ST_IDLE);
        end
    end

    // Datapath: length capture, byte assembly, address stepping and sticky error
    always_ff @(posedge Clk) begin
        if (Reset) begin
            len_r  <= 8'd0;
            I_addr <= 7'd0;
            I_data <= 16'h0000;
            Err    <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (Start) begin
                        if (len_ok_s) begin
                            len_r  <= Len;
                            I_addr <= 7'd0;
                            Err    <= 1'b0;
                        end else begin
                            Err <= 1'b1;
                        end
                    end
                end
                ST_HI: begin
                    if (xfer_s) begin
                        I_data[15:8] <= In_data;
                    end
                end
                ST_LO: begin
                    if (xfer_s) begin
`ifdef PROG_LOADER_OPCHECK_EN
                        // Illegal opcodes are replaced by a NOOP so the program stays executable
                        if (opcode_illegal(I_data[15:12])) begin
                            I_data <= 16'h0000;
                            Err    <= 1'b1;
                        end else begin
                            I_data[7:0] <= In_data;
                        end
`else
                        I_data[7:0] <= In_data;
`endif
                    end
                end
                ST_WRITE: begin
                    // The address is held at the last word so it never wraps
                    if (!last_word_s) begin
                        I_addr <= I_addr + 7'd1;
                    end
                end
                ST_FINISH: begin
                    I_addr <= I_addr;
                end
                default: begin
                    I_addr <= I_addr;
                end
            endcase
        end
    end

`ifndef PROG_LOADER_OPCHECK_EN
    logic unused_opcheck_s;
    assign unused_opcheck_s = opcode_illegal(4'd0);
`endif

endmodule

// File: tb/tb_prog_loader.sv
// Directed self-checking bench for prog_loader.
module tb_prog_loader;

    logic        Clk = 1'b0;
    logic        Reset, Start, In_valid;
    logic [7:0]  Len, In_data;
    logic        In_ready, I_wr, Cpu_reset, Busy, Done, Err;
    logic [6:0]  I_addr;
    logic [15:0] I_data;

    int total = 0;
    int passed = 0;
    int cycle = 0;
    int ndone = 0;
    int wr_addr_q[$];
    logic [15:0] wr_data_q[$];
    int wr_cyc_q[$];

    prog_loader dut (
        .Clk(Clk), .Reset(Reset), .Start(Start), .Len(Len),
        .In_valid(In_valid), .In_data(In_data), .In_ready(In_ready),
        .I_addr(I_addr), .I_data(I_data), .I_wr(I_wr),
        .Cpu_reset(Cpu_reset), .Busy(Busy), .Done(Done), .Err(Err)
    );

    always #5 Clk = ~Clk;

    // Write/Done monitor sampled on the falling edge
    always @(negedge Clk) begin
        cycle = cycle + 1;
        if (I_wr === 1'b1) begin
            wr_addr_q.push_back(int'(I_addr));
            wr_data_q.push_back(I_data);
            wr_cyc_q.push_back(cycle);
        end
        if (Done === 1'b1) ndone = ndone + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic start_load(input logic [7:0] len);
        Start = 1'b1;
        Len = len;
        tick();
        Start = 1'b0;
    endtask

    task automatic send_byte(input string tag, input logic [7:0] b);
        int n;
        n = 0;
        In_valid = 1'b1;
        In_data = b;
        while (In_ready !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        chk(tag, {31'd0, In_ready}, 32'd1);
        tick();
        In_valid = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (Busy !== 1'b0 && n < 1000) begin
            tick();
            n++;
        end
        chk(tag, {31'd0, (n < 1000)}, 32'd1);
    endtask

    initial begin
        int nw0, nd0;
        Reset = 1'b1; Start = 1'b0; Len = 8'd0; In_valid = 1'b0; In_data = 8'd0;
        tick();
        chk("rst_addr", {25'd0, I_addr}, 32'd0);
        chk("rst_data", {16'd0, I_data}, 32'd0);
        chk("rst_ctl", {26'd0, I_wr, In_ready, Busy, Done, Err, Cpu_reset}, 32'd1);
        Reset = 1'b0;
        tick();
        chk("rst_cpu_fall", {31'd0, Cpu_reset}, 32'd0);

        // Two words, In_valid held high
        nw0 = wr_addr_q.size(); nd0 = ndone;
        start_load(8'd2);
        chk("t1_busy", {29'd0, Busy, Cpu_reset, In_ready}, 32'd7);
        send_byte("t1_b0", 8'h21);
        send_byte("t1_b1", 8'h43);
        send_byte("t1_b2", 8'h55);
        send_byte("t1_b3", 8'h00);
        wait_idle("t1_idle");
        tick();
        chk("t1_nwr", wr_addr_q.size() - nw0, 32'd2);
        chk("t1_a0", wr_addr_q[nw0], 32'd0);
        chk("t1_d0", {16'd0, wr_data_q[nw0]}, 32'h2143);
        chk("t1_a1", wr_addr_q[nw0+1], 32'd1);
        chk("t1_d1", {16'd0, wr_data_q[nw0+1]}, 32'h5500);
        chk("t1_gap", wr_cyc_q[nw0+1] - wr_cyc_q[nw0], 32'd3);
        chk("t1_done", ndone - nd0, 32'd1);
        chk("t1_cpu", {31'd0, Cpu_reset}, 32'd0);

        // One word with a 4-cycle stall, plus an ignored illegal Start mid-load
        nw0 = wr_addr_q.size();
        start_load(8'd1);
        send_byte("t2_hi", 8'hAB);
        for (int i = 0; i < 4; i++) begin
            if (i == 0) begin Start = 1'b1; Len = 8'd0; end
            tick();
            Start = 1'b0;
            chk("t2_ready_gap", {31'd0, In_ready}, 32'd1);
        end
        chk("t2_err_ignored", {31'd0, Err}, 32'd0);
        send_byte("t2_lo", 8'hCD);
        wait_idle("t2_idle");
        chk("t2_nwr", wr_addr_q.size() - nw0, 32'd1);
        chk("t2_a", wr_addr_q[nw0], 32'd0);
        chk("t2_d", {16'd0, wr_data_q[nw0]}, 32'hABCD);

        // Illegal lengths
        nw0 = wr_addr_q.size();
        start_load(8'd0);
        chk("t3_len0", {30'd0, Err, Busy}, 32'd2);
        tick();
        start_load(8'd129);
        chk("t3_len129", {30'd0, Err, Busy}, 32'd2);
        tick(); tick();
        chk("t3_nwr", wr_addr_q.size() - nw0, 32'd0);

        // Full 128-word load, incrementing bytes; accepted Start clears Err
        nw0 = wr_addr_q.size(); nd0 = ndone;
        start_load(8'd128);
        chk("t4_err_clr", {31'd0, Err}, 32'd0);
        for (int w = 0; w < 128; w++) begin
            send_byte("t4_hi", 8'(2 * w));
            send_byte("t4_lo", 8'(2 * w + 1));
        end
        wait_idle("t4_idle");
        for (int i = 0; i < 5; i++) tick();
        chk("t4_nwr", wr_addr_q.size() - nw0, 32'd128);
        chk("t4_first", {16'd0, wr_data_q[nw0]}, 32'h0001);
        chk("t4_last_a", wr_addr_q[wr_addr_q.size()-1], 32'd127);
        chk("t4_last_d", {16'd0, wr_data_q[wr_data_q.size()-1]}, 32'hFEFF);
        chk("t4_done", ndone - nd0, 32'd1);

        // Reset during the low byte of word 3 of a 10-word load
        nw0 = wr_addr_q.size(); nd0 = ndone;
        start_load(8'd10);
        for (int w = 0; w < 3; w++) begin
            send_byte("t5_hi", 8'h10);
            send_byte("t5_lo", 8'h20);
        end
        send_byte("t5_hi3", 8'h30);
        Reset = 1'b1; In_valid = 1'b1; In_data = 8'h40;
        tick();
        Reset = 1'b0; In_valid = 1'b0;
        chk("t5_abort", {28'd0, Busy, In_ready, I_wr, Cpu_reset}, 32'd1);
        tick();
        chk("t5_cpu_fall", {31'd0, Cpu_reset}, 32'd0);
        for (int i = 0; i < 5; i++) tick();
        chk("t5_nwr", wr_addr_q.size() - nw0, 32'd3);
        chk("t5_nodone", ndone - nd0, 32'd0);

        // Opcode check
        nw0 = wr_addr_q.size();
        start_load(8'd1);
        send_byte("t6_hi", 8'h71);
        send_byte("t6_lo", 8'h23);
        wait_idle("t6_idle");
        chk("t6_nwr", wr_addr_q.size() - nw0, 32'd1);
`ifdef PROG_LOADER_OPCHECK_EN
        chk("t6_d", {16'd0, wr_data_q[nw0]}, 32'h0000);
        chk("t6_err", {31'd0, Err}, 32'd1);
`else
        chk("t6_d", {16'd0, wr_data_q[nw0]}, 32'h7123);
        chk("t6_err", {31'd0, Err}, 32'd0);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
